// File: rtl/ev22_decode_stage.sv
// EV22 instruction decode stage: registered opcode decode with a valid/ready
// output, K-prefix pairing, call-depth tracking and illegal-opcode flagging.
module ev22_decode_stage #(
  parameter int RW       = 5,
  parameter int DEPTH    = 8,
  parameter int W_SEL    = 2**RW+2,
  parameter int NONE_SEL = 2**RW+3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    opcode,
  input  logic [RW-1:0] ri,
  input  logic [RW-1:0] rj,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_c,
  output logic [1:0]    sh,
  output logic          k_mux,
  output logic          mr,
  output logic          mw,
  output logic [RW-1:0] sel_a,
  output logic [RW:0]   sel_b,
  output logic [RW:0]   sel_c,
  output logic [6:0]    itype,
  output logic          k_full,
  output logic          illegal,
  output logic [7:0]    call_depth,
  output logic          stack_err
);

  localparam logic [RW:0] SW   = (RW+1)'(W_SEL);
  localparam logic [RW:0] SN   = (RW+1)'(NONE_SEL);
  localparam logic [7:0]  DMAX = 8'(DEPTH);

  typedef struct packed {
    logic [3:0]    alu_c;
    logic [1:0]    sh;
    logic          k_mux;
    logic          mr;
    logic          mw;
    logic [RW-1:0] sel_a;
    logic [RW:0]   sel_b;
    logic [RW:0]   sel_c;
    logic [6:0]    itype;
    logic          k_full;
    logic          illegal;
  } ctl_t;

  typedef enum logic {IDLE, PEND} pst_t;

  pst_t  st;
  ctl_t  d;
  ctl_t  q;
  logic  acc;
  logic  [RW:0] ri_x;

  logic m_jmp, m_jzn, m_jcy, m_momw, m_momr;
  logic m_adw, m_bsr, m_movrr, m_movrw;
  logic m_mokl, m_mokw, m_ank, m_ork, m_adk;
  logic m_movwr, m_anr, m_orr, m_adr;
  logic m_cpl, m_clc, m_sec, m_ret;

  assign in_ready = !out_valid | out_ready;
  assign acc      = in_valid & in_ready;
  assign ri_x     = {1'b0, ri};

  assign m_jmp   = opcode[7:3] == 5'b00100;
  assign m_jzn   = (opcode[7:3] == 5'b00101) |
                   (opcode[7:3] == 5'b00110);
  assign m_jcy   = opcode[7:3] == 5'b00111;
  assign m_momw  = opcode[7:2] == 6'b000100;
  assign m_momr  = opcode[7:2] == 6'b000101;
  assign m_adw   = opcode[7:2] == 6'b000110;
  assign m_bsr   = opcode[7:2] == 6'b000111;
  assign m_movrr = opcode[7:2] == 6'b000010;
  assign m_movrw = opcode[7:2] == 6'b000011;
  assign m_mokl  = opcode == 8'h04;
  assign m_mokw  = opcode == 8'h44;
  assign m_ank   = opcode == 8'h45;
  assign m_ork   = opcode == 8'h46;
  assign m_adk   = opcode == 8'h47;
  assign m_movwr = opcode == 8'h02;
  assign m_anr   = opcode == 8'h42;
  assign m_orr   = opcode == 8'h03;
  assign m_adr   = opcode == 8'h43;
  assign m_cpl   = opcode == 8'h00;
  assign m_clc   = opcode == 8'h40;
  assign m_sec   = opcode == 8'h01;
  assign m_ret   = opcode == 8'h41;

  always_comb begin
    d       = '0;
    d.sel_a = rj;
    d.sel_c = SN;
    unique case (1'b1)
      m_jmp: d.itype = 7'b1000000;
      m_jzn: d.itype = 7'b1000001;
      m_jcy: d.itype = 7'b1010000;
      m_momw: begin
        d.mw    = 1'b1;
        d.itype = 7'b0000001;
      end
      m_momr: begin
        d.mr    = 1'b1;
        d.itype = 7'b0000010;
      end
      m_adw: begin
        d.alu_c = 4'b0101;
        d.sel_b = SW;
        d.sel_c = ri_x;
        d.itype = 7'b0111101;
      end
      m_bsr: begin
        d.mr    = 1'b1;
        d.itype = 7'b1000000;
      end
      m_movrr: begin
        d.sel_b = SW;
        d.sel_c = ri_x;
        d.itype = 7'b0001100;
      end
      m_movrw: begin
        d.alu_c = 4'b0001;
        d.sel_b = SW;
        d.sel_c = ri_x;
        d.itype = 7'b0001001;
      end
      m_mokl: begin
        d.k_mux = 1'b1;
        d.itype = 7'b0000010;
      end
      m_mokw: begin
        d.k_mux = 1'b1;
        d.sel_c = SW;
        d.itype = 7'b0000010;
      end
      m_ank, m_ork: begin
        d.alu_c = m_ank ? 4'b0111 : 4'b0110;
        d.k_mux = 1'b1;
        d.sel_b = SW;
        d.sel_c = SW;
        d.itype = 7'b0000011;
      end
      m_adk: begin
        d.alu_c = 4'b0101;
        d.k_mux = 1'b1;
        d.sel_b = SW;
        d.sel_c = SW;
        d.itype = 7'b0110011;
      end
      m_movwr: begin
        d.sel_c = SW;
        d.itype = 7'b0000110;
      end
      m_anr, m_orr: begin
        d.alu_c = m_anr ? 4'b0111 : 4'b0110;
        d.sel_b = SW;
        d.sel_c = SW;
        d.itype = 7'b0000111;
      end
      m_adr: begin
        d.alu_c = 4'b0101;
        d.sel_b = SW;
        d.sel_c = SW;
        d.itype = 7'b0110111;
      end
      m_cpl: begin
        d.alu_c = 4'b0011;
        d.sel_b = SW;
        d.sel_c = SW;
        d.itype = 7'b0000011;
      end
      m_clc: begin
        d.alu_c = 4'b1011;
        d.itype = 7'b0100000;
      end
      m_sec: begin
        d.alu_c = 4'b1100;
        d.itype = 7'b0100000;
      end
      m_ret: d.itype = 7'b1000000;
      default: begin
        d.illegal = 1'b1;
        d.sel_a   = '0;
      end
    endcase
    // K-group opcodes pair with a MOK #K_LSB accepted just before them
    d.k_full = (st == PEND) && (opcode[7:2] == 6'b010001);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '0;
      q.sel_c    <= SN;
      out_valid  <= 1'b0;
      st         <= IDLE;
      call_depth <= '0;
      stack_err  <= 1'b0;
    end else if (acc) begin
      q         <= d;
      out_valid <= 1'b1;
      st        <= m_mokl ? PEND : IDLE;
      if (m_bsr) begin
        if (call_depth < DMAX) call_depth <= call_depth + 8'd1;
        else stack_err <= 1'b1;
      end
      if (m_ret) begin
        if (call_depth != 8'd0) call_depth <= call_depth - 8'd1;
        else stack_err <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_c   = q.alu_c;
  assign sh      = q.sh;
  assign k_mux   = q.k_mux;
  assign mr      = q.mr;
  assign mw      = q.mw;
  assign sel_a   = q.sel_a;
  assign sel_b   = q.sel_b;
  assign sel_c   = q.sel_c;
  assign itype   = q.itype;
  assign k_full  = q.k_full;
  assign illegal = q.illegal;

endmodule

// File: tb/tb_ev22_decode_stage.sv
// Bench for ev22_decode_stage: default build plus an RW=6/DEPTH=2 build,
// checked against an opcode-table reference model.
module tb_ev22_decode_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       iv, ir, ov, ordy;
  logic [7:0] op;
  logic [4:0] ri, rj, sa;
  logic [5:0] sb, sc;
  logic [3:0] alu;
  logic [1:0] sh;
  logic       km, mr, mw, kf, il, se;
  logic [6:0] it;
  logic [7:0] cd;

  logic       iv2, ir2, ov2, ordy2;
  logic [7:0] op2;
  logic [5:0] ri2, rj2, sa2;
  logic [6:0] sb2, sc2;
  logic [3:0] alu2;
  logic [1:0] sh2;
  logic       km2, mr2, mw2, kf2, il2, se2;
  logic [6:0] it2;
  logic [7:0] cd2;

  ev22_decode_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(iv), .in_ready(ir),
    .opcode(op), .ri(ri), .rj(rj),
    .out_valid(ov), .out_ready(ordy),
    .alu_c(alu), .sh(sh), .k_mux(km),
    .mr(mr), .mw(mw),
    .sel_a(sa), .sel_b(sb), .sel_c(sc),
    .itype(it), .k_full(kf), .illegal(il),
    .call_depth(cd), .stack_err(se)
  );

  ev22_decode_stage #(.RW(6), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(iv2), .in_ready(ir2),
    .opcode(op2), .ri(ri2), .rj(rj2),
    .out_valid(ov2), .out_ready(ordy2),
    .alu_c(alu2), .sh(sh2), .k_mux(km2),
    .mr(mr2), .mw(mw2),
    .sel_a(sa2), .sel_b(sb2), .sel_c(sc2),
    .itype(it2), .k_full(kf2), .illegal(il2),
    .call_depth(cd2), .stack_err(se2)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sh;
    logic       km, mr, mw;
    logic [7:0] sa, sb, sc;
    logic [6:0] it;
    logic       kf, il;
  } ctl_t;

  int total = 0;
  int bad   = 0;

  bit   m_pend;
  int   m_depth;
  bit   m_err;
  bit   e_ov;
  ctl_t e_ctl;

  function automatic ctl_t ref_dec(input logic [7:0] o, input int a,
                                   input int b, input int rw,
                                   input bit pend);
    ctl_t c;
    int w;
    w    = (1 << rw) + 2;
    c    = '0;
    c.sa = 8'(b);
    c.sc = 8'(w + 1);
    casez (o)
      8'b00100???: c.it = 7'b1000000;
      8'b00101???,
      8'b00110???: c.it = 7'b1000001;
      8'b00111???: c.it = 7'b1010000;
      8'b000100??: begin c.mw = 1; c.it = 7'b0000001; end
      8'b000101??: begin c.mr = 1; c.it = 7'b0000010; end
      8'b000110??: begin
        c.alu = 5; c.sb = 8'(w); c.sc = 8'(a); c.it = 7'b0111101;
      end
      8'b000111??: begin c.mr = 1; c.it = 7'b1000000; end
      8'b000010??: begin
        c.sb = 8'(w); c.sc = 8'(a); c.it = 7'b0001100;
      end
      8'b000011??: begin
        c.alu = 1; c.sb = 8'(w); c.sc = 8'(a); c.it = 7'b0001001;
      end
      8'h04: begin c.km = 1; c.it = 7'b0000010; end
      8'h44: begin c.km = 1; c.sc = 8'(w); c.it = 7'b0000010; end
      8'h45, 8'h46, 8'h47: begin
        c.alu = (o == 8'h45) ? 4'd7 : (o == 8'h46) ? 4'd6 : 4'd5;
        c.km  = 1; c.sb = 8'(w); c.sc = 8'(w);
        c.it  = (o == 8'h47) ? 7'b0110011 : 7'b0000011;
      end
      8'h02: begin c.sc = 8'(w); c.it = 7'b0000110; end
      8'h42, 8'h03, 8'h43: begin
        c.alu = (o == 8'h42) ? 4'd7 : (o == 8'h03) ? 4'd6 : 4'd5;
        c.sb  = 8'(w); c.sc = 8'(w);
        c.it  = (o == 8'h43) ? 7'b0110111 : 7'b0000111;
      end
      8'h00: begin
        c.alu = 3; c.sb = 8'(w); c.sc = 8'(w); c.it = 7'b0000011;
      end
      8'h40: begin c.alu = 11; c.it = 7'b0100000; end
      8'h01: begin c.alu = 12; c.it = 7'b0100000; end
      8'h41: c.it = 7'b1000000;
      default: begin c.il = 1; c.sa = 0; end
    endcase
    if (o[7:2] == 6'b010001) c.kf = pend;
    return c;
  endfunction

  function automatic ctl_t obs_a();
    return {alu, sh, km, mr, mw, 8'(sa), 8'(sb), 8'(sc), it, kf, il};
  endfunction

  task automatic model_accept(input logic [7:0] o);
    m_pend = (o == 8'h04);
    if (o[7:2] == 6'b000111) begin
      if (m_depth < 8) m_depth++;
      else m_err = 1;
    end
    if (o == 8'h41) begin
      if (m_depth > 0) m_depth--;
      else m_err = 1;
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_depth = 0; m_err = 0; e_ov = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; iv = 0; iv2 = 0; ordy = 1; ordy2 = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] o, input logic [4:0] a,
                      input logic [4:0] b, output ctl_t e);
    @(negedge clk);
    iv = 1; op = o; ri = a; rj = b; ordy = 1;
    e = ref_dec(o, a, b, 5, m_pend);
    model_accept(o);
    @(posedge clk); #1;
    iv = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if (ov !== 1'b0) begin
      bad++; $display("FAIL reset_ov got %b want 0", ov);
    end
    total++;
    if (sc !== 6'd35 || sb !== 6'd0 || il !== 1'b0) begin
      bad++; $display("FAIL reset_sel got sc=%0d sb=%0d il=%b want 35 0 0",
                      sc, sb, il);
    end
    total++;
    if (cd !== 8'd0 || se !== 1'b0 || ir !== 1'b1) begin
      bad++; $display("FAIL reset_depth got cd=%0d se=%b ir=%b want 0 0 1",
                      cd, se, ir);
    end
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic test_sweep();
    ctl_t e;
    do_reset();
    for (int o = 0; o < 256; o++) begin
      send(8'(o), 5'd3, 5'd7, e);
      total++;
      if (ov !== 1'b1 || obs_a() !== e) begin
        bad++;
        $display("FAIL sweep op=%02h got ov=%b ctl=%h want 1 %h",
                 o, ov, obs_a(), e);
      end
    end
    total++;
    if (cd !== 8'(m_depth) || se !== m_err) begin
      bad++; $display("FAIL sweep_depth got %0d/%b want %0d/%b",
                      cd, se, m_depth, m_err);
    end
  endtask

  task automatic test_backpressure();
    ctl_t e, e2;
    send(8'h45, 5'd1, 5'd2, e);
    @(negedge clk);
    ordy = 0; iv = 1; op = 8'h00; ri = 5'd4; rj = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ir !== 1'b0) begin
        bad++; $display("FAIL bp_ready cyc=%0d got %b want 0", i, ir);
      end
      @(posedge clk); #1;
      total++;
      if (ov !== 1'b1 || obs_a() !== e) begin
        bad++; $display("FAIL bp_hold cyc=%0d got %b %h want 1 %h",
                        i, ov, obs_a(), e);
      end
      @(negedge clk);
    end
    ordy = 1;
    #1;
    total++;
    if (ir !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready got %b want 1", ir);
    end
    e2 = ref_dec(8'h00, 4, 5, 5, m_pend);
    model_accept(8'h00);
    @(posedge clk); #1;
    iv = 0;
    total++;
    if (ov !== 1'b1 || obs_a() !== e2) begin
      bad++; $display("FAIL bp_next got %b %h want 1 %h", ov, obs_a(), e2);
    end
  endtask

  task automatic test_prefix();
    ctl_t e;
    send(8'h04, 5'd0, 5'd0, e);
    send(8'h47, 5'd0, 5'd0, e);
    total++;
    if (kf !== 1'b1 || obs_a() !== e) begin
      bad++; $display("FAIL prefix_pair got kf=%b %h want 1 %h",
                      kf, obs_a(), e);
    end
    send(8'h04, 5'd0, 5'd0, e);
    send(8'h00, 5'd0, 5'd0, e);
    send(8'h47, 5'd0, 5'd0, e);
    total++;
    if (kf !== 1'b0 || obs_a() !== e) begin
      bad++; $display("FAIL prefix_broken got kf=%b %h want 0 %h",
                      kf, obs_a(), e);
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      op   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 8'h47))
                                         : 8'($urandom);
      ri   = 5'($urandom);
      rj   = 5'($urandom);
      #1;
      total++;
      if (ir !== (!e_ov || ordy)) begin
        bad++; $display("FAIL rnd_ready i=%0d got %b want %b",
                        i, ir, (!e_ov || ordy));
      end
      acc = iv && (!e_ov || ordy);
      if (acc) begin
        e_ctl = ref_dec(op, ri, rj, 5, m_pend);
        model_accept(op);
        e_ov = 1;
      end else if (ordy) begin
        e_ov = 0;
      end
      @(posedge clk); #1;
      total++;
      if (ov !== e_ov || (e_ov && obs_a() !== e_ctl)) begin
        bad++; $display("FAIL rnd_out i=%0d got %b %h want %b %h",
                        i, ov, obs_a(), e_ov, e_ctl);
      end
      total++;
      if (cd !== 8'(m_depth) || se !== m_err) begin
        bad++; $display("FAIL rnd_depth i=%0d got %0d/%b want %0d/%b",
                        i, cd, se, m_depth, m_err);
      end
    end
    iv = 0; ordy = 1;
  endtask

  task automatic test_depth();
    logic [7:0] ops [6];
    logic [7:0] ecd [6];
    logic       ese [6];
    ops = '{8'h1c, 8'h1d, 8'h1f, 8'h41, 8'h41, 8'h41};
    ecd = '{8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};
    ese = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      iv2 = 1; op2 = ops[i]; ri2 = 6'd0; rj2 = 6'd0; ordy2 = 1;
      @(posedge clk); #1;
      iv2 = 0;
      total++;
      if (cd2 !== ecd[i] || se2 !== ese[i]) begin
        bad++; $display("FAIL depth2 step=%0d got %0d/%b want %0d/%b",
                        i, cd2, se2, ecd[i], ese[i]);
      end
    end
  endtask

  task automatic test_reset_stall();
    ctl_t e;
    do_reset();
    send(8'h1d, 5'd2, 5'd3, e);
    @(negedge clk);
    ordy = 0; iv = 0;
    @(posedge clk); #1;
    total++;
    if (ov !== 1'b1 || cd !== 8'd1 || obs_a() !== e) begin
      bad++; $display("FAIL stall_pre got ov=%b cd=%0d %h want 1 1 %h",
                      ov, cd, obs_a(), e);
    end
    #2 reset = 1;
    #1;
    total++;
    if (ov !== 1'b0 || sc !== 6'd35 || cd !== 8'd0 || mr !== 1'b0) begin
      bad++; $display("FAIL stall_reset got ov=%b sc=%0d cd=%0d mr=%b want 0 35 0 0",
                      ov, sc, cd, mr);
    end
    @(negedge clk);
    reset = 0; ordy = 1;
    model_reset();
  endtask

  task automatic test_rw6();
    @(negedge clk);
    iv2 = 1; op2 = 8'h0c; ri2 = 6'd40; rj2 = 6'd9; ordy2 = 1;
    @(posedge clk); #1;
    iv2 = 0;
    total++;
    if (ov2 !== 1'b1 || sc2 !== 7'd40 || sb2 !== 7'd66 || sa2 !== 6'd9 ||
        alu2 !== 4'b0001 || it2 !== 7'b0001001 || il2 !== 1'b0) begin
      bad++; $display("FAIL rw6_mov got ov=%b sc=%0d sb=%0d sa=%0d alu=%b it=%b want 1 40 66 9 0001 0001001",
                      ov2, sc2, sb2, sa2, alu2, it2);
    end
    @(negedge clk);
    iv2 = 1; op2 = 8'h80;
    @(posedge clk); #1;
    iv2 = 0;
    total++;
    if (il2 !== 1'b1 || sc2 !== 7'd67 || sb2 !== 7'd0) begin
      bad++; $display("FAIL rw6_illegal got il=%b sc=%0d sb=%0d want 1 67 0",
                      il2, sc2, sb2);
    end
  endtask

  initial begin
    reset = 1; iv = 0; iv2 = 0; ordy = 1; ordy2 = 1;
    op = 0; ri = 0; rj = 0; op2 = 0; ri2 = 0; rj2 = 0;
    model_reset();
    test_reset();
    test_sweep();
    test_backpressure();
    test_prefix();
    test_random();
    test_depth();
    test_reset_stall();
    test_rw6();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ev22_decode_stage.md
# ev22_decode_stage

Registered, parametrised instruction-decode stage for the EV22 core, sitting between instruction fetch and the execute datapath. Each accepted 8-bit opcode plus register fields is decoded into ALU, memory, selector and type controls and presented one cycle later through a valid/ready handshake. Beyond plain decoding, it tracks K-immediate prefix pairing, maintains a saturating call-depth counter for BSR/RET, and flags illegal opcodes.

## Interface
- RW, 5: register-index width; selector outputs are RW+1 bits.
- DEPTH, 8: maximum call depth (1..255).
- W_SEL, 2**RW+2: selector code for W (34 at RW=5).
- NONE_SEL, 2**RW+3: selector code for "no destination" (35 at RW=5).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  opcode/ri/rj valid
- in_ready  out  1  stage can accept
- opcode  in  8  instruction opcode
- ri  in  RW  destination register field
- rj  in  RW  source register field
- out_valid  out  1  decoded controls valid
- out_ready  in  1  execute consumes controls
- alu_c  out  4  ALU function
- sh  out  2  shifter control (always 0 this generation)
- k_mux  out  1  select K operand
- mr / mw  out  1 each  memory read / write
- sel_a  out  RW  A-bus select (= rj)
- sel_b  out  RW+1  B-bus select
- sel_c  out  RW+1  C-bus (destination) select
- itype  out  7  instruction type vector
- k_full  out  1  K instruction paired with preceding MOK #K_LSB
- illegal  out  1  opcode not in map; all other controls NOP
- call_depth  out  8  current depth
- stack_err  out  1  sticky over/underflow

## Operation
- Opcode map (alu_c / sel_b / sel_c / itype; unlisted fields 0, sel_c NONE_SEL):
  - 00100xxx JMP: -/0/NONE/1000000. 00101xxx JZE, 00110xxx JNE: 1000001. 00111xxx JCY: 1010000.
  - 000100yy MOM Y,W: mw=1, itype 0000001. 000101yy MOM W,Y: mr=1, 0000010.
  - 000110ii ADW: 0101/W/ri/0111101. 000111ss BSR: mr=1, 1000000, call push.
  - 000010ii MOV Ri,Rj: 0000/W/ri/0001100. 000011ii MOV Ri,W: 0001/W/ri/0001001.
  - 00000100 MOK #K_LSB: k_mux=1, 0000010. 01000100 MOK W,#K: k_mux=1, sel_c W, 0000010.
  - 01000101 ANK 0111, 01000110 ORK 0110: k_mux=1, W/W, 0000011. 01000111 ADK: 0101, k_mux=1, W/W, 0110011.
  - 00000010 MOV W,Rj: sel_c W, 0000110. 01000010 ANR: 0111/W/W/0000111. 00000011 ORR: 0110/W/W/0000111. 01000011 ADR: 0101/W/W/0110111.
  - 00000000 CPL: 0011/W/W/0000011. 01000000 CLR CY: 1011, 0100000. 00000001 SET CY: 1100, 0100000. 01000001 RET: 1000000, call pop.
  - Anything else: illegal=1, NOP controls.
- ri used in sel_c is zero-extended to RW+1 bits.
- Prefix FSM, states IDLE/PEND: accepting MOK #K_LSB -> PEND; accepting any other opcode -> IDLE. k_full=1 on an accepted 0100 01xx opcode while in PEND.
- Call depth: BSR accepted at depth<DEPTH -> +1; at DEPTH -> hold, stack_err=1. RET at depth>0 -> -1; at 0 -> hold, stack_err=1. stack_err clears only on reset.

## Timing
- Acceptance: in_valid & in_ready. in_ready = !out_valid | out_ready (full throughput, no bubble).
- Latency 1 cycle: controls registered on acceptance, out_valid high next cycle.
- Held output stable while out_valid & !out_ready; in_ready low then.
- Simultaneous drain and accept: new controls replace old in same edge.
- Prefix state, call_depth and stack_err update on acceptance edge only.
- Reset (any time, incl. mid-stall): out_valid=0, controls NOP (alu_c/sh/k_mux/mr/mw/sel_a/sel_b/itype/k_full/illegal=0, sel_c=NONE_SEL), FSM IDLE, call_depth=0, stack_err=0; held instruction discarded.

## Test plan
- Opcode sweep 0x00-0xFF, ri=3, rj=7, out_ready=1 -> e.g. 0x18 gives alu_c 0101, sel_b 34, sel_c 3, sel_a 7, itype 0111101; 0x80 gives illegal=1; one cycle latency each.
- Backpressure: accept 0x45, hold out_ready=0 three cycles -> outputs stable, in_ready=0; release -> next opcode accepted same cycle.
- Prefix: 0x04, 0x47 -> k_full=1 on second; 0x04, 0x00, 0x47 -> k_full=0.
- DEPTH=2: BSR x3 -> call_depth 2, stack_err=1; RET x3 -> 0, stack_err stays 1.
- Assert reset mid-stall with out_valid=1 -> out_valid=0, sel_c 35, call_depth 0 immediately.
- RW=6 build: MOV Ri,W with ri=40 -> sel_c 40, sel_b 66.
